// File: rtl/cache_ctrl_nway.sv
// cache_ctrl_nway: blocking 1/2-way write-back cache controller with per-set LRU,
// dirty-victim writeback and pipelined multi-word line fill.
module cache_ctrl_nway #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int INDEX_W = 8,
  parameter int WORDS   = 4,
  parameter int WAYS    = 2,
  parameter int MEM_LAT = 2,
  parameter int OFF_W   = $clog2(WORDS),
  parameter int TAG_W   = ADDR_W - INDEX_W - OFF_W - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Rd,
  input  logic                     Wr,
  input  logic [ADDR_W-1:0]        Addr,
  input  logic [DATA_W-1:0]        DataIn,
  output logic [DATA_W-1:0]        DataOut,
  output logic                     Done,
  output logic                     CacheHit,
  output logic                     Stall,
  output logic                     err,
  output logic [WAYS-1:0]          cache_en,
  output logic [INDEX_W-1:0]       cache_index,
  output logic [OFF_W:0]           cache_offset,
  output logic                     cache_cmp,
  output logic                     cache_wr,
  output logic [TAG_W-1:0]         cache_tag_in,
  output logic [DATA_W-1:0]        cache_data_in,
  output logic                     cache_valid_in,
  input  logic [WAYS-1:0]          cache_hit,
  input  logic [WAYS-1:0]          cache_dirty,
  input  logic [WAYS-1:0]          cache_valid,
  input  logic [WAYS*TAG_W-1:0]    cache_tag_out,
  input  logic [WAYS*DATA_W-1:0]   cache_data_out,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data_in,
  output logic                     mem_rd,
  output logic                     mem_wr,
  input  logic [DATA_W-1:0]        mem_data_out,
  input  logic                     mem_stall
);
  typedef enum logic [2:0] {IDLE = 3'd0, WB = 3'd1, FILL = 3'd2, RETRY = 3'd3} state_t;
  state_t state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d, vtag_q, vtag_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [OFF_W-1:0] off_q, off_d, ret_q, ret_d;
  logic [OFF_W:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic wr_q, wr_d, v_q, v_d;
  logic [MEM_LAT-1:0] pipe_q, pipe_d;
  logic [2**INDEX_W-1:0] lru_q, lru_d;
  logic [TAG_W-1:0] a_tag;
  logic [INDEX_W-1:0] a_idx;
  logic [OFF_W-1:0] a_off;
  logic [WAYS-1:0] hv, v_en;
  logic hit_multi, hit_way, vict, vict_dirty;
  logic [DATA_W-1:0] vdata;
  assign a_tag = Addr[ADDR_W-1 -: TAG_W];
  assign a_idx = Addr[OFF_W+1 +: INDEX_W];
  assign a_off = Addr[1 +: OFF_W];
  assign hv = cache_hit & cache_valid;
  assign hit_multi = |(hv & (hv - WAYS'(1)));
  assign hit_way = (WAYS > 1) ? hv[WAYS-1] : 1'b0;
  // Prefer an empty way; otherwise the set's LRU bit names the victim.
  assign vict = (WAYS == 1 || !cache_valid[0]) ? 1'b0 : (!cache_valid[WAYS-1] ? 1'b1 : lru_q[a_idx]);
  assign vict_dirty = cache_valid[vict] & cache_dirty[vict];
  assign v_en = WAYS'(1) << v_q;
  assign vdata = cache_data_out[v_q*DATA_W +: DATA_W];
  always_comb begin
    state_d = state_q;
    tag_d = tag_q;
    vtag_d = vtag_q;
    idx_d = idx_q;
    off_d = off_q;
    ret_d = ret_q;
    cnt_d = cnt_q;
    din_d = din_q;
    wr_d = wr_q;
    v_d = v_q;
    lru_d = lru_q;
    pipe_d = pipe_q << 1;
    DataOut = '0;
    Done = 1'b0;
    CacheHit = 1'b0;
    Stall = 1'b0;
    err = 1'b0;
    cache_en = '0;
    cache_index = idx_q;
    cache_offset = {off_q, 1'b0};
    cache_cmp = 1'b0;
    cache_wr = 1'b0;
    cache_tag_in = tag_q;
    cache_data_in = din_q;
    mem_addr = '0;
    mem_data_in = '0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    case (state_q)
      IDLE: if (Rd || Wr) begin
        cache_index = a_idx;
        cache_offset = {a_off, 1'b0};
        cache_tag_in = a_tag;
        cache_data_in = DataIn;
        if ((Rd && Wr) || Addr[0]) err = 1'b1;
        else begin
          cache_en = '1;
          cache_cmp = 1'b1;
          cache_wr = Wr & ~hit_multi;
          if (hit_multi) err = 1'b1;
          else if (|hv) begin
            Done = 1'b1;
            CacheHit = 1'b1;
            DataOut = cache_data_out[hit_way*DATA_W +: DATA_W];
            if (WAYS > 1) lru_d[a_idx] = ~hit_way;
          end else begin
            tag_d = a_tag;
            idx_d = a_idx;
            off_d = a_off;
            din_d = DataIn;
            wr_d = Wr;
            v_d = vict;
            vtag_d = cache_tag_out[vict*TAG_W +: TAG_W];
            cnt_d = '0;
            ret_d = '0;
            state_d = vict_dirty ? WB : FILL;
          end
        end
      end
      WB: begin
        Stall = 1'b1;
        cache_en = v_en;
        cache_offset = {cnt_q[OFF_W-1:0], 1'b0};
        mem_wr = 1'b1;
        mem_addr = {vtag_q, idx_q, cnt_q[OFF_W-1:0], 1'b0};
        mem_data_in = vdata;
        if (!mem_stall) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == (OFF_W+1)'(WORDS - 1)) begin
            cnt_d = '0;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        Stall = 1'b1;
        if (cnt_q != (OFF_W+1)'(WORDS)) begin
          mem_rd = 1'b1;
          mem_addr = {tag_q, idx_q, cnt_q[OFF_W-1:0], 1'b0};
          if (!mem_stall) begin
            cnt_d = cnt_q + 1'b1;
            pipe_d[0] = 1'b1;
          end
        end
        // Returns arrive in issue order, so a running count names the word.
        if (pipe_q[MEM_LAT-1]) begin
          cache_en = v_en;
          cache_wr = 1'b1;
          cache_offset = {ret_q, 1'b0};
          cache_data_in = mem_data_out;
          ret_d = ret_q + 1'b1;
          if (ret_q == OFF_W'(WORDS - 1)) state_d = RETRY;
        end
      end
      RETRY: begin
        cache_en = v_en;
        cache_cmp = 1'b1;
        cache_wr = wr_q;
        Done = 1'b1;
        DataOut = wr_q ? '0 : vdata;
        cnt_d = '0;
        if (WAYS > 1) lru_d[idx_q] = ~v_q;
        state_d = IDLE;
      end
      default: begin
        err = 1'b1;
        state_d = IDLE;
      end
    endcase
    cache_valid_in = cache_wr;
    if (rst) begin
      DataOut = '0;
      Done = 1'b0;
      CacheHit = 1'b0;
      Stall = 1'b0;
      err = 1'b0;
      cache_en = '0;
      cache_wr = 1'b0;
      cache_cmp = 1'b0;
      cache_valid_in = 1'b0;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tag_q <= '0;
      vtag_q <= '0;
      idx_q <= '0;
      off_q <= '0;
      ret_q <= '0;
      cnt_q <= '0;
      din_q <= '0;
      wr_q <= 1'b0;
      v_q <= 1'b0;
      lru_q <= '0;
      pipe_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q <= tag_d;
      vtag_q <= vtag_d;
      idx_q <= idx_d;
      off_q <= off_d;
      ret_q <= ret_d;
      cnt_q <= cnt_d;
      din_q <= din_d;
      wr_q <= wr_d;
      v_q <= v_d;
      lru_q <= lru_d;
      pipe_q <= pipe_d;
    end
  end
endmodule

// File: tb/tb_cache_ctrl_nway.sv
// tb_cache_ctrl_nway: directed bench with a behavioural 2-way cache array and
// a fixed-latency memory whose word at address a reads as a ^ 16'hA5A5.
module tb_cache_ctrl_nway;
  logic clk = 1'b0, rst = 1'b1;
  logic Rd = 1'b0, Wr = 1'b0, mem_stall = 1'b0;
  logic [15:0] Addr = '0, DataIn = '0;
  logic [15:0] DataOut, cache_data_in, mem_addr, mem_data_in, mem_data_out;
  logic Done, CacheHit, Stall, err, cache_cmp, cache_wr, cache_valid_in, mem_rd, mem_wr;
  logic [1:0] cache_en, cache_hit, cache_dirty, cache_valid;
  logic [7:0] cache_index;
  logic [2:0] cache_offset;
  logic [4:0] cache_tag_in;
  logic [9:0] cache_tag_out;
  logic [31:0] cache_data_out;
  logic m_val [2][256];
  logic m_dirty [2][256];
  logic [4:0] m_tag [2][256];
  logic [15:0] m_data [2][256][4];
  logic pl_en = 1'b0, pl_w = 1'b0, pl_d = 1'b0;
  logic [7:0] pl_i = '0;
  logic [4:0] pl_t = '0;
  logic [15:0] pl_data = '0;
  logic [15:0] ra1 = '0, ra2 = '0;
  logic [15:0] rq[$], wq_a[$], wq_d[$];
  int pass_n = 0, fail_n = 0, total = 0, lat, rb, wb;
  logic s1;

  cache_ctrl_nway dut (
    .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
    .DataOut(DataOut), .Done(Done), .CacheHit(CacheHit), .Stall(Stall), .err(err),
    .cache_en(cache_en), .cache_index(cache_index), .cache_offset(cache_offset),
    .cache_cmp(cache_cmp), .cache_wr(cache_wr), .cache_tag_in(cache_tag_in),
    .cache_data_in(cache_data_in), .cache_valid_in(cache_valid_in),
    .cache_hit(cache_hit), .cache_dirty(cache_dirty), .cache_valid(cache_valid),
    .cache_tag_out(cache_tag_out), .cache_data_out(cache_data_out),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  always_comb begin
    cache_hit = '0;
    cache_valid = '0;
    cache_dirty = '0;
    cache_tag_out = '0;
    cache_data_out = '0;
    for (int w = 0; w < 2; w++) begin
      cache_valid[w] = m_val[w][cache_index];
      cache_dirty[w] = m_dirty[w][cache_index];
      cache_tag_out[w*5 +: 5] = m_tag[w][cache_index];
      cache_data_out[w*16 +: 16] = m_data[w][cache_index][cache_offset[2:1]];
      cache_hit[w] = cache_cmp && m_val[w][cache_index] && (m_tag[w][cache_index] == cache_tag_in);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < 2; w++)
        for (int i = 0; i < 256; i++) begin
          m_val[w][i] <= 1'b0;
          m_dirty[w][i] <= 1'b0;
        end
    end else if (pl_en) begin
      m_val[pl_w][pl_i] <= 1'b1;
      m_dirty[pl_w][pl_i] <= pl_d;
      m_tag[pl_w][pl_i] <= pl_t;
      for (int k = 0; k < 4; k++) m_data[pl_w][pl_i][k] <= pl_data + 16'(k);
    end else begin
      for (int w = 0; w < 2; w++)
        if (cache_en[w] && cache_wr) begin
          if (!cache_cmp) begin
            m_data[w][cache_index][cache_offset[2:1]] <= cache_data_in;
            m_val[w][cache_index] <= cache_valid_in;
            m_tag[w][cache_index] <= cache_tag_in;
            m_dirty[w][cache_index] <= 1'b0;
          end else if (cache_hit[w]) begin
            m_data[w][cache_index][cache_offset[2:1]] <= cache_data_in;
            m_dirty[w][cache_index] <= 1'b1;
          end
        end
    end
  end

  assign mem_data_out = ra2 ^ 16'hA5A5;
  always @(posedge clk) begin
    ra1 <= (mem_rd && !mem_stall) ? mem_addr : 16'h0;
    ra2 <= ra1;
    if (mem_rd && !mem_stall) rq.push_back(mem_addr);
    if (mem_wr && !mem_stall) begin
      wq_a.push_back(mem_addr);
      wq_d.push_back(mem_data_in);
    end
  end

  task automatic chk(input string nm, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s: got %h, expected %h", nm, o, e);
    end
  endtask

  task automatic req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    Rd = r;
    Wr = w;
    Addr = a;
    DataIn = d;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    Rd = 1'b0;
    Wr = 1'b0;
    #1;
  endtask

  task automatic preload(input logic w, input logic [7:0] i, input logic [4:0] t,
                         input logic d, input logic [15:0] base);
    @(negedge clk);
    pl_en = 1'b1; pl_w = w; pl_i = i; pl_t = t; pl_d = d; pl_data = base;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_done(input int st, input int sl, output int l, output logic s);
    l = 0;
    s = 1'b0;
    for (int c = 1; c <= 40 && l == 0; c++) begin
      @(negedge clk);
      Rd = 1'b0;
      Wr = 1'b0;
      mem_stall = (c >= st && c < st + sl);
      #1;
      if (c == 1) s = Stall;
      if (Done) l = c;
    end
    mem_stall = 1'b0;
  endtask

  initial begin
    // Reset with a request pending: every strobe must stay low
    Rd = 1'b1;
    Addr = 16'h1234;
    @(negedge clk);
    #1;
    chk("rst_done", Done, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_err", err, 0);
    chk("rst_cache_en", cache_en, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_dataout", DataOut, 0);
    @(negedge clk);
    rst = 1'b0;
    Rd = 1'b0;

    // Clean read miss at 0x1234: tag 2, index 0x46, word 2
    rb = rq.size();
    req(1, 0, 16'h1234, 0);
    chk("miss_req_en", cache_en, 2'b11);
    chk("miss_req_cmp", cache_cmp, 1);
    chk("miss_req_idx", cache_index, 8'h46);
    chk("miss_req_tag", cache_tag_in, 5'd2);
    chk("miss_req_off", cache_offset, 3'b100);
    chk("miss_req_done", Done, 0);
    wait_done(99, 0, lat, s1);
    chk("miss_stall_c1", s1, 1);
    chk("miss_latency", lat, 7);
    chk("miss_hit", CacheHit, 0);
    chk("miss_data", DataOut, 16'hB791);
    idle();
    chk("miss_after_stall", Stall, 0);
    chk("miss_after_done", Done, 0);
    chk("miss_after_en", cache_en, 0);
    chk("miss_rd_cnt", rq.size() - rb, 4);
    chk("miss_rd0", rq[rb], 16'h1230);
    chk("miss_rd1", rq[rb+1], 16'h1232);
    chk("miss_rd2", rq[rb+2], 16'h1234);
    chk("miss_rd3", rq[rb+3], 16'h1236);
    chk("miss_fill0", m_data[0][8'h46][0], 16'hB795);
    chk("miss_fill3", m_data[0][8'h46][3], 16'hB793);
    chk("miss_tag", m_tag[0][8'h46], 5'd2);

    // Hits: way1 line at index 0x10, tag 3
    preload(1, 8'h10, 5'd3, 0, 16'hBEEF);
    req(1, 0, 16'h1880, 0);
    chk("hit_done", Done, 1);
    chk("hit_cachehit", CacheHit, 1);
    chk("hit_data", DataOut, 16'hBEEF);
    chk("hit_stall", Stall, 0);
    chk("hit_mem_rd", mem_rd, 0);
    req(1, 0, 16'h1884, 0);
    chk("hit_w2_data", DataOut, 16'hBEF1);
    req(1, 0, 16'h1236, 0);
    chk("hit_filled_data", DataOut, 16'hB793);
    chk("hit_filled_done", Done, 1);
    req(0, 1, 16'h1882, 16'h1357);
    chk("whit_done", Done, 1);
    chk("whit_wr", cache_wr, 1);
    idle();
    chk("idle_en", cache_en, 0);
    chk("idle_done", Done, 0);
    chk("whit_data", m_data[1][8'h10][1], 16'h1357);
    chk("whit_dirty", m_dirty[1][8'h10], 1);

    // Dirty write miss, index 0x20, both ways valid, LRU=0 -> way0 written back
    preload(0, 8'h20, 5'd1, 1, 16'h1110);
    preload(1, 8'h20, 5'd4, 0, 16'h4440);
    rb = rq.size();
    wb = wq_a.size();
    req(0, 1, 16'h3906, 16'h5A5A);
    wait_done(99, 0, lat, s1);
    chk("wmiss_latency", lat, 11);
    chk("wmiss_hit", CacheHit, 0);
    idle();
    chk("wmiss_wb_cnt", wq_a.size() - wb, 4);
    chk("wmiss_wb0_a", wq_a[wb], 16'h0900);
    chk("wmiss_wb0_d", wq_d[wb], 16'h1110);
    chk("wmiss_wb3_a", wq_a[wb+3], 16'h0906);
    chk("wmiss_wb3_d", wq_d[wb+3], 16'h1113);
    chk("wmiss_rd0", rq[rb], 16'h3900);
    chk("wmiss_fill0", m_data[0][8'h20][0], 16'h9CA5);
    chk("wmiss_word3", m_data[0][8'h20][3], 16'h5A5A);
    chk("wmiss_dirty", m_dirty[0][8'h20], 1);
    chk("wmiss_tag", m_tag[0][8'h20], 5'd7);

    // LRU now 1: next miss in the set must evict clean way1, no writeback
    wb = wq_a.size();
    req(1, 0, 16'h4900, 0);
    wait_done(99, 0, lat, s1);
    chk("lru_latency", lat, 7);
    chk("lru_data", DataOut, 16'hECA5);
    idle();
    chk("lru_way1_tag", m_tag[1][8'h20], 5'd9);
    chk("lru_way0_tag", m_tag[0][8'h20], 5'd7);
    chk("lru_no_wb", wq_a.size() - wb, 0);

    // Memory stall for 3 cycles while issuing word 2
    rb = rq.size();
    req(1, 0, 16'h1180, 0);
    wait_done(3, 3, lat, s1);
    chk("stall_latency", lat, 10);
    chk("stall_data", DataOut, 16'hB425);
    idle();
    chk("stall_rd_cnt", rq.size() - rb, 4);
    chk("stall_rd2", rq[rb+2], 16'h1184);
    chk("stall_fill1", m_data[0][8'h30][1], 16'hB427);
    chk("stall_fill2", m_data[0][8'h30][2], 16'hB421);
    chk("stall_fill3", m_data[0][8'h30][3], 16'hB423);

    // Error cases
    req(1, 1, 16'h1880, 16'hFFFF);
    chk("rdwr_err", err, 1);
    chk("rdwr_done", Done, 0);
    chk("rdwr_en", cache_en, 0);
    chk("rdwr_memrd", mem_rd, 0);
    chk("rdwr_memwr", mem_wr, 0);
    idle();
    chk("rdwr_err_clear", err, 0);
    req(1, 0, 16'h1881, 0);
    chk("odd_err", err, 1);
    chk("odd_done", Done, 0);
    chk("odd_en", cache_en, 0);
    preload(0, 8'h50, 5'd5, 0, 16'h0500);
    preload(1, 8'h50, 5'd5, 0, 16'h0600);
    req(0, 1, 16'h2A80, 16'hDEAD);
    chk("multi_err", err, 1);
    chk("multi_done", Done, 0);
    chk("multi_wr", cache_wr, 0);
    idle();
    chk("multi_nowrite", m_data[0][8'h50][0], 16'h0500);

    // Reset during FILL abandons the miss
    req(1, 0, 16'h0300, 0);
    idle();
    idle();
    chk("rfill_mem_rd", mem_rd, 1);
    chk("rfill_stall", Stall, 1);
    #1 rst = 1'b1;
    #1;
    chk("rfill_rst_stall", Stall, 0);
    chk("rfill_rst_mem_rd", mem_rd, 0);
    chk("rfill_rst_wr", cache_wr, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rfill_post_stall", Stall, 0);
    chk("rfill_post_mem_rd", mem_rd, 0);
    idle();
    chk("rfill_post2_stall", Stall, 0);
    chk("rfill_post2_mem_rd", mem_rd, 0);
    chk("rfill_post2_done", Done, 0);

    $display("%0d/%0d checks passed", pass_n, total);
    $finish;
  end
endmodule
